unidade_controle_jogo: RTL

UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

---
 rtl/unidade_controle_jogo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/unidade_controle_jogo.sv
// Game control unit: Moore FSM sequencing menu, move timing, map scrolling and win/lose.
// Outputs are registered from the next-state decode, so they always match db_estado.
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirma,
  input  logic       colisao,
  input  logic       fim_espera,
  input  logic       fim_mapa,
  output logic       zeraPosicoes,
  output logic       resetaVidas,
  output logic       zeraT,
  output logic       contaT,
  output logic       move_drone,
  output logic       desloca_horizontal,
  output logic       escolhe_modo,
  output logic       escolhe_vida,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    MODO     = 4'h2,
    VIDA     = 4'h3,
    INICIA   = 4'h4,
    ESPERA   = 4'h5,
    DESLOCA  = 4'h6,
    VERIFICA = 4'h7,
    CARREGA  = 4'h8,
    GANHOU   = 4'h9,
    PERDEU   = 4'hA
  } estado_t;

  estado_t     estado_r;
  estado_t     proximo_s;
  logic        iniciar_r;
  logic        confirma_r;
  logic        iniciar_borda_s;
  logic        confirma_borda_s;
  logic [10:0] saidas_r;

  // Bit order: zeraPosicoes, resetaVidas, zeraT, contaT, move_drone, desloca_horizontal,
  // escolhe_modo, escolhe_vida, ganhou, perdeu, pronto.
  function automatic logic [10:0] decodifica(input estado_t e);
    case (e)
      PREPARA: decodifica = 11'b111_0000_0000;
      MODO:    decodifica = 11'b000_0001_0000;
      VIDA:    decodifica = 11'b000_0000_1000;
      INICIA:  decodifica = 11'b001_0000_0000;
      ESPERA:  decodifica = 11'b000_1100_0000;
      DESLOCA: decodifica = 11'b001_0010_0000;
      GANHOU:  decodifica = 11'b000_0000_0101;
      PERDEU:  decodifica = 11'b000_0000_0011;
      default: decodifica = 11'b000_0000_0000;
    endcase
  endfunction

  assign iniciar_borda_s  = iniciar & ~iniciar_r;
  assign confirma_borda_s = confirma & ~confirma_r;

  // State, edge-detect history and output registers; edge history resets high so held levels do not count.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r   <= INICIAL;
      iniciar_r  <= 1'b1;
      confirma_r <= 1'b1;
      saidas_r   <= 11'b0;
    end else begin
      estado_r   <= proximo_s;
      iniciar_r  <= iniciar;
      confirma_r <= confirma;
      saidas_r   <= decodifica(proximo_s);
    end
  end

  // Next-state logic; collision takes priority over reaching the map end.
  always_comb begin
    proximo_s = INICIAL;
    case (estado_r)
      INICIAL:  proximo_s = iniciar_borda_s ? PREPARA : INICIAL;
      PREPARA:  proximo_s = MODO;
      MODO:     proximo_s = confirma_borda_s ? VIDA : MODO;
      VIDA:     proximo_s = confirma_borda_s ? INICIA : VIDA;
      INICIA:   proximo_s = ESPERA;
      ESPERA:   proximo_s = fim_espera ? DESLOCA : ESPERA;
      DESLOCA:  proximo_s = CARREGA;
      CARREGA:  proximo_s = VERIFICA;
      VERIFICA: begin
        if (colisao) begin
          proximo_s = PERDEU;
        end else if (fim_mapa) begin
          proximo_s = GANHOU;
        end else begin
          proximo_s = ESPERA;
        end
      end
      GANHOU:   proximo_s = iniciar_borda_s ? PREPARA : GANHOU;
      PERDEU:   proximo_s = iniciar_borda_s ? PREPARA : PERDEU;
      default:  proximo_s = INICIAL;
    endcase
  end

  assign db_estado          = estado_r;
  assign zeraPosicoes       = saidas_r[10];
  assign resetaVidas        = saidas_r[9];
  assign zeraT              = saidas_r[8];
  assign contaT             = saidas_r[7];
  assign move_drone         = saidas_r[6];
  assign desloca_horizontal = saidas_r[5];
  assign escolhe_modo       = saidas_r[4];
  assign escolhe_vida       = saidas_r[3];
  assign ganhou             = saidas_r[2];
  assign perdeu             = saidas_r[1];
  assign pronto             = saidas_r[0];

endmodule
